// File: rtl/mining_pkg.sv
// rtl/mining_pkg.sv - shared types and default sizes for the nonce scheduler slice
package mining_pkg;

  localparam int NONCE_W_DEF     = 32;
  localparam int HASH_W_DEF      = 256;
  localparam int TIMEOUT_CYC_DEF = 512;

  typedef enum logic [2:0] {
    SCHED_IDLE    = 3'd0,
    SCHED_START   = 3'd1,
    SCHED_WAIT    = 3'd2,
    SCHED_CHECK   = 3'd3,
    SCHED_FOUND   = 3'd4,
    SCHED_EXHAUST = 3'd5,
    SCHED_QUIT    = 3'd6
  } sched_state_t;

endpackage

// File: rtl/nonce_scheduler_if.sv
// rtl/nonce_scheduler_if.sv - job/host and hashing-module signals of the nonce scheduler
interface nonce_scheduler_if #(
  parameter int NONCE_W = mining_pkg::NONCE_W_DEF,
  parameter int HASH_W  = mining_pkg::HASH_W_DEF
);

  logic               job_valid;
  logic               job_ready;
  logic [NONCE_W-1:0] nonce_start;
  logic [NONCE_W-1:0] nonce_end;
  logic [HASH_W-1:0]  target;
  logic               abort;
  logic               hash_done;
  logic [HASH_W-1:0]  hash_out;
  logic               begin_hash;
  logic               quit_hash;
  logic [NONCE_W-1:0] nonce;
  logic               busy;
  logic               found;
  logic [NONCE_W-1:0] found_nonce;
  logic               exhausted;
  logic               timeout_err;
  logic [NONCE_W-1:0] attempts;

  // slave is the scheduler; master is whoever plays host plus hashing module
  modport slave (
    input  job_valid, nonce_start, nonce_end, target, abort, hash_done, hash_out,
    output job_ready, begin_hash, quit_hash, nonce, busy, found, found_nonce,
           exhausted, timeout_err, attempts
  );

  modport master (
    output job_valid, nonce_start, nonce_end, target, abort, hash_done, hash_out,
    input  job_ready, begin_hash, quit_hash, nonce, busy, found, found_nonce,
           exhausted, timeout_err, attempts
  );

endinterface

// File: rtl/hash_target_compare.sv
// rtl/hash_target_compare.sv - unsigned digest < target comparator
module hash_target_compare #(
  parameter int HASH_W = 256
) (
  input  logic [HASH_W-1:0] digest,
  input  logic [HASH_W-1:0] target,
  output logic              lt
);

  assign lt = (digest < target);

endmodule

// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - walks a nonce range through the hashing module for one job
module nonce_scheduler
  import mining_pkg::*;
#(
  parameter int NONCE_W     = NONCE_W_DEF,
  parameter int HASH_W      = HASH_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic              clk,
  input logic              rst,
  nonce_scheduler_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = SCHED_IDLE;
  localparam logic [2:0] ST_START   = SCHED_START;
  localparam logic [2:0] ST_WAIT    = SCHED_WAIT;
  localparam logic [2:0] ST_CHECK   = SCHED_CHECK;
  localparam logic [2:0] ST_FOUND   = SCHED_FOUND;
  localparam logic [2:0] ST_EXHAUST = SCHED_EXHAUST;
  localparam logic [2:0] ST_QUIT    = SCHED_QUIT;

  localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]         state;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] nonce_end_q;
  logic [HASH_W-1:0]  target_q;
  logic [HASH_W-1:0]  digest_q;
  logic [NONCE_W-1:0] found_nonce_q;
  logic [NONCE_W-1:0] attempts_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               hit;

  hash_target_compare #(.HASH_W(HASH_W)) u_cmp (
    .digest (digest_q),
    .target (target_q),
    .lt     (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
      digest_q      <= '0;
      found_nonce_q <= '0;
      attempts_q    <= '0;
      timeout_q     <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.job_valid) begin
            nonce_q       <= bus.nonce_start;
            nonce_end_q   <= bus.nonce_end;
            target_q      <= bus.target;
            attempts_q    <= '0;
            found_nonce_q <= '0;
            timeout_q     <= 1'b0;
            state         <= ST_START;
          end
        end
        ST_START: begin
          wait_cnt <= '0;
          state    <= bus.abort ? ST_QUIT : ST_WAIT;
        end
        ST_WAIT: begin
          // abort outranks a same-cycle result, which is then simply dropped
          if (bus.abort) begin
            state <= ST_QUIT;
          end else if (bus.hash_done) begin
            digest_q <= bus.hash_out;
            state    <= ST_CHECK;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_q <= 1'b1;
            state     <= ST_QUIT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (bus.abort) begin
            state <= ST_QUIT;
          end else begin
            if (attempts_q != '1) attempts_q <= attempts_q + NONCE_W'(1);
            if (hit) begin
              found_nonce_q <= nonce_q;
              state         <= ST_FOUND;
            end else if (nonce_q == nonce_end_q) begin
              state <= ST_EXHAUST;
            end else begin
              nonce_q <= nonce_q + NONCE_W'(1);
              state   <= ST_START;
            end
          end
        end
        ST_FOUND, ST_EXHAUST, ST_QUIT: state <= ST_IDLE;
        default:                       state <= ST_IDLE;
      endcase
    end
  end

  assign bus.job_ready   = (state == ST_IDLE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.begin_hash  = (state == ST_START);
  assign bus.quit_hash   = (state == ST_QUIT);
  assign bus.found       = (state == ST_FOUND);
  assign bus.exhausted   = (state == ST_EXHAUST);
  assign bus.nonce       = nonce_q;
  assign bus.found_nonce = found_nonce_q;
  assign bus.attempts    = attempts_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb/tb_nonce_scheduler.sv - randomized self-checking bench for nonce_scheduler
module tb_nonce_scheduler;

  localparam int TO = 512;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [255:0] dig_map [bit [31:0]];
  logic [255:0] miss_dig;

  nonce_scheduler_if #(.NONCE_W(32), .HASH_W(256)) bus ();

  nonce_scheduler #(.NONCE_W(32), .HASH_W(256), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] dig(input logic [31:0] n);
    if (dig_map.exists(n)) return dig_map[n];
    return miss_dig;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: list the nonces that should be hashed and the job outcome (1 found, 2 exhausted)
  task automatic run_job(input string name, input logic [31:0] s, input logic [31:0] e,
                         input logic [255:0] tgt);
    logic [31:0] exp_n[$];
    logic [31:0] n;
    logic [31:0] exp_fn;
    logic [31:0] want;
    int exp_res, idx, cd, exp_evt, res, res_cyc;
    bit stop;
    n = s; stop = 0; exp_res = 2; exp_fn = 0;
    for (int k = 0; k < 1000 && !stop; k++) begin
      exp_n.push_back(n);
      if (dig(n) < tgt) begin
        exp_res = 1; exp_fn = n; stop = 1;
      end else if (n == e) begin
        stop = 1;
      end else begin
        n = n + 32'd1;
      end
    end

    @(negedge clk);
    bus.nonce_start = s; bus.nonce_end = e; bus.target = tgt; bus.job_valid = 1'b1;
    idx = 0; cd = 0; exp_evt = 1; res = 0; res_cyc = 0;
    for (int cyc = 1; cyc < 20000 && res == 0; cyc++) begin
      @(negedge clk);
      bus.hash_done   = 1'b0;
      bus.job_valid   = 1'($urandom_range(0, 1));
      bus.nonce_start = $urandom;
      bus.nonce_end   = $urandom;
      bus.target      = rand256();
      if (bus.begin_hash) begin
        want = (idx < exp_n.size()) ? exp_n[idx] : 32'hDEAD_BEEF;
        n_cmp++;
        if (cyc != exp_evt || idx >= exp_n.size() || bus.nonce !== want) begin
          n_bad++;
          $display("FAIL %s begin_hash #%0d: nonce %h at cycle %0d, required %h at cycle %0d",
                   name, idx, bus.nonce, cyc, want, exp_evt);
        end
        if (idx == 0) begin
          n_cmp++;
          if (bus.timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s timeout_err after accept: %b, required 0", name, bus.timeout_err);
          end
        end
        idx++;
        cd = $urandom_range(1, 5);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.hash_done = 1'b1;
          bus.hash_out  = dig(bus.nonce);
          exp_evt = cyc + 2;
        end
      end
      if (bus.found) res = 1;
      else if (bus.exhausted) res = 2;
      else if (bus.quit_hash) res = 3;
      if (res != 0) begin
        bus.job_valid = 1'b0;
        res_cyc = cyc;
      end
    end

    n_cmp++;
    if (res != exp_res || res_cyc != exp_evt) begin
      n_bad++;
      $display("FAIL %s outcome: %0d at cycle %0d, required %0d at cycle %0d",
               name, res, res_cyc, exp_res, exp_evt);
    end
    n_cmp++;
    if (idx != exp_n.size()) begin
      n_bad++;
      $display("FAIL %s hash count: %0d, required %0d", name, idx, exp_n.size());
    end
    n_cmp++;
    if (bus.attempts !== 32'(exp_n.size())) begin
      n_bad++;
      $display("FAIL %s attempts: %0d, required %0d", name, bus.attempts, exp_n.size());
    end
    n_cmp++;
    if (bus.found_nonce !== exp_fn) begin
      n_bad++;
      $display("FAIL %s found_nonce: %h, required %h", name, bus.found_nonce, exp_fn);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.job_ready !== 1'b1 || bus.found !== 1'b0 || bus.exhausted !== 1'b0) begin
      n_bad++;
      $display("FAIL %s back to idle: ready=%b found=%b exh=%b, required 1 0 0",
               name, bus.job_ready, bus.found, bus.exhausted);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0 || bus.begin_hash !== 1'b0 ||
        bus.quit_hash !== 1'b0 || bus.found !== 1'b0 || bus.exhausted !== 1'b0 ||
        bus.timeout_err !== 1'b0 || bus.nonce !== 32'd0 || bus.attempts !== 32'd0 ||
        bus.found_nonce !== 32'd0) begin
      n_bad++;
      $display("FAIL reset state: ready=%b busy=%b bh=%b qh=%b f=%b ex=%b to=%b n=%h at=%h fn=%h",
               bus.job_ready, bus.busy, bus.begin_hash, bus.quit_hash, bus.found,
               bus.exhausted, bus.timeout_err, bus.nonce, bus.attempts, bus.found_nonce);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_hit();
    dig_map.delete();
    miss_dig = 256'd1 << 241;
    dig_map[32'h13] = 256'd1 << 200;
    run_job("hit", 32'h10, 32'h20, 256'd1 << 240);
  endtask

  task automatic test_exhaust();
    dig_map.delete();
    miss_dig = '1;
    run_job("exhaust", 32'h5, 32'h5, 256'd1 << 240);
  endtask

  task automatic test_wrap();
    dig_map.delete();
    miss_dig = '1;
    run_job("wrap", 32'hFFFF_FFFE, 32'h1, 256'd1 << 240);
  endtask

  // Digest equal to target must not count as a hit, so target doubles as the miss digest
  task automatic test_random();
    logic [31:0] s;
    logic [31:0] key;
    logic [255:0] tgt;
    int len;
    for (int it = 0; it < 8; it++) begin
      s   = (it == 0) ? 32'hFFFF_FFFD : $urandom;
      len = $urandom_range(0, 5);
      tgt = rand256();
      miss_dig = tgt;
      dig_map.delete();
      for (int k = 0; k <= len; k++) begin
        key = s + 32'(k);
        if ($urandom_range(0, 3) == 0) dig_map[key] = rand256();
      end
      run_job("random", s, s + 32'(len), tgt);
    end
  endtask

  task automatic test_abort();
    dig_map.delete();
    miss_dig = '0;
    @(negedge clk);
    bus.nonce_start = 32'h40; bus.nonce_end = 32'h40; bus.target = '1; bus.job_valid = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    n_cmp++;
    if (bus.begin_hash !== 1'b1) begin
      n_bad++;
      $display("FAIL abort begin_hash: %b, required 1", bus.begin_hash);
    end
    repeat (2) @(negedge clk);
    bus.hash_done = 1'b1; bus.hash_out = '0; bus.abort = 1'b1;
    @(negedge clk);
    bus.hash_done = 1'b0; bus.abort = 1'b0;
    n_cmp++;
    if (bus.quit_hash !== 1'b1 || bus.found !== 1'b0 || bus.attempts !== 32'd0) begin
      n_bad++;
      $display("FAIL abort quit: quit=%b found=%b attempts=%0d, required 1 0 0",
               bus.quit_hash, bus.found, bus.attempts);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.job_ready !== 1'b1 || bus.found !== 1'b0 || bus.found_nonce !== 32'd0) begin
      n_bad++;
      $display("FAIL abort idle: ready=%b found=%b found_nonce=%h, required 1 0 0",
               bus.job_ready, bus.found, bus.found_nonce);
    end
  endtask

  task automatic test_timeout();
    int q;
    bit seen, stray;
    @(negedge clk);
    bus.nonce_start = 32'h7; bus.nonce_end = 32'h7; bus.target = '1; bus.job_valid = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    n_cmp++;
    if (bus.begin_hash !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout begin_hash: %b, required 1", bus.begin_hash);
    end
    seen = 0; stray = 0; q = 0;
    for (int c = 2; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (bus.found || bus.exhausted) stray = 1;
      if (bus.quit_hash) begin
        seen = 1; q = c;
        n_cmp++;
        if (bus.timeout_err !== 1'b1) begin
          n_bad++;
          $display("FAIL timeout_err at quit: %b, required 1", bus.timeout_err);
        end
      end
    end
    n_cmp++;
    if (!seen || q != TO + 2 || stray) begin
      n_bad++;
      $display("FAIL timeout quit cycle: seen=%0d cycle=%0d stray=%0d, required 1 %0d 0",
               seen, q, stray, TO + 2);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.timeout_err !== 1'b1 || bus.job_ready !== 1'b1 || bus.attempts !== 32'd0) begin
      n_bad++;
      $display("FAIL timeout sticky: to=%b ready=%b attempts=%0d, required 1 1 0",
               bus.timeout_err, bus.job_ready, bus.attempts);
    end
    dig_map.delete();
    miss_dig = '1;
    dig_map[32'h22] = '0;
    run_job("after_timeout", 32'h20, 32'h30, 256'd5);
  endtask

  task automatic test_reset_mid();
    int quits;
    @(negedge clk);
    bus.nonce_start = 32'h100; bus.nonce_end = 32'h1FF; bus.target = '1; bus.job_valid = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.nonce !== 32'h100) begin
      n_bad++;
      $display("FAIL reset_mid in wait: busy=%b nonce=%h, required 1 00000100", bus.busy, bus.nonce);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.job_ready !== 1'b1 || bus.nonce !== 32'd0 ||
        bus.begin_hash !== 1'b0 || bus.quit_hash !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid async: busy=%b ready=%b nonce=%h bh=%b qh=%b, required 0 1 0 0 0",
               bus.busy, bus.job_ready, bus.nonce, bus.begin_hash, bus.quit_hash);
    end
    quits = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.quit_hash) quits++;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.quit_hash) quits++;
    end
    n_cmp++;
    if (quits != 0) begin
      n_bad++;
      $display("FAIL reset_mid quit_hash pulses: %0d, required 0", quits);
    end
    dig_map.delete();
    miss_dig = '1;
    dig_map[32'h302] = 256'd1;
    run_job("after_reset", 32'h300, 32'h305, 256'd2);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.job_valid = 1'b0; bus.nonce_start = '0; bus.nonce_end = '0; bus.target = '0;
    bus.abort = 1'b0; bus.hash_done = 1'b0; bus.hash_out = '0;
    miss_dig = '1;
    test_reset();
    test_hit();
    test_exhaust();
    test_wrap();
    test_random();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
